// File: rtl/eth_frame_fifo.sv
// Frame-aware single-clock FIFO: words become readable only once their frame is
// committed; dropped or overflowing frames are rewound to the last commit point.
module eth_frame_fifo #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH       = 11,
  parameter int unsigned ALMOST_FULL_NUM  = 1024,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  output logic                  wr_full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_commit,
  output logic                  wr_discard,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic [ADDR_WIDTH:0]   frame_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AF_LVL   = LW'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_LVL   = LW'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH:0]  mem [0:DEPTH-1];
  logic [ADDR_WIDTH:0]  wr_ptr;
  logic [ADDR_WIDTH:0]  commit_ptr;
  logic [ADDR_WIDTH:0]  rd_ptr;
  logic                 ovf;
  logic                 acc;
  logic                 frame_end;
  logic                 do_commit;
  logic                 rd_fire;
  logic [DATA_WIDTH:0]  rd_word;

  assign wr_level     = wr_ptr - rd_ptr;
  assign rd_level     = commit_ptr - rd_ptr;
  assign wr_full      = (wr_level == FULL_LVL);
  assign rd_empty     = (commit_ptr == rd_ptr);
  assign almost_full  = (wr_level >= AF_LVL);
  assign almost_empty = (rd_level <= AE_LVL);

  assign acc       = wr_en && !wr_full && !ovf;
  assign frame_end = wr_en && wr_last;
  assign do_commit = frame_end && !(wr_drop || ovf || wr_full);
  assign rd_fire   = rd_en && !rd_empty;
  assign rd_word   = mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {wr_last, wr_data};
  end

  // A discard rewinds to commit_ptr; rd_ptr never passes commit_ptr, so this is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      ovf        <= 1'b0;
      wr_commit  <= 1'b0;
      wr_discard <= 1'b0;
    end else begin
      wr_commit  <= 1'b0;
      wr_discard <= 1'b0;
      if (frame_end) begin
        if (do_commit) begin
          commit_ptr <= wr_ptr + ONE;
          wr_ptr     <= wr_ptr + ONE;
          wr_commit  <= 1'b1;
        end else begin
          wr_ptr     <= commit_ptr;
          ovf        <= 1'b0;
          wr_discard <= 1'b1;
        end
      end else if (wr_en) begin
        if (acc) wr_ptr <= wr_ptr + ONE;
        else     ovf    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_ptr  <= rd_ptr + ONE;
        rd_data <= rd_word[DATA_WIDTH-1:0];
        rd_last <= rd_word[DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else begin
      case ({do_commit, rd_fire && rd_word[DATA_WIDTH]})
        2'b10:   frame_cnt <= frame_cnt + ONE;
        2'b01:   frame_cnt <= frame_cnt - ONE;
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

endmodule
